// File: rtl/psone_pkg.sv
// Shared constants and types for the PS1 pad response decoder.
package psone_pkg;

  localparam logic [7:0] ID_DIGITAL = 8'h41;
  localparam logic [7:0] ID_RED     = 8'h73;
  localparam logic [7:0] ID_GREEN   = 8'h53;
  localparam logic [7:0] MARKER     = 8'h5A;
  localparam logic [7:0] CENTRE     = 8'h80;
  localparam int         PKT_LEN    = 9;

  typedef enum logic [1:0] {
    MODE_NONE  = 2'd0,
    MODE_DIG   = 2'd1,
    MODE_RED   = 2'd2,
    MODE_GREEN = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

  typedef struct packed {
    logic [15:0]       buttons;
    logic signed [7:0] rx;
    logic signed [7:0] ry;
    logic signed [7:0] lx;
    logic signed [7:0] ly;
    mode_e             mode;
  } report_t;

  // Map the pad ID byte to a mode; unknown IDs map to MODE_NONE.
  function automatic mode_e id_to_mode(input logic [7:0] id);
    case (id)
      ID_DIGITAL: return MODE_DIG;
      ID_RED:     return MODE_RED;
      ID_GREEN:   return MODE_GREEN;
      default:    return MODE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/psone_report_if.sv
// Byte-stream input and report handshake bundle of the pad decoder.
interface psone_report_if;
  logic              iBYTE_VAL;
  logic [7:0]        iBYTE;
  logic              iPKT_ST;
  logic              iRDY;
  logic              oREP_VAL;
  logic [15:0]       oBUTTONS;
  logic signed [7:0] oRX;
  logic signed [7:0] oRY;
  logic signed [7:0] oLX;
  logic signed [7:0] oLY;
  logic [1:0]        oMODE;
  logic              oCHANGED;
  logic              oERR;
  logic              oDROP;
  logic [7:0]        oERR_CNT;

  modport slave (
    input  iBYTE_VAL, iBYTE, iPKT_ST, iRDY,
    output oREP_VAL, oBUTTONS, oRX, oRY, oLX, oLY, oMODE,
           oCHANGED, oERR, oDROP, oERR_CNT
  );

  modport master (
    output iBYTE_VAL, iBYTE, iPKT_ST, iRDY,
    input  oREP_VAL, oBUTTONS, oRX, oRY, oLX, oLY, oMODE,
           oCHANGED, oERR, oDROP, oERR_CNT
  );
endinterface

// File: rtl/psone_axis.sv
// Raw stick byte to centred, dead-zoned signed axis value (combinational).
module psone_axis
  import psone_pkg::*;
#(
  parameter int DEADZONE = 8
) (
  input  logic [7:0]        raw,
  output logic signed [7:0] val
);

  logic signed [7:0] d;

  // Magnitude needs 9 bits so that |-128| = 128 stays outside any dead zone.
  function automatic logic [8:0] mag9(input logic signed [7:0] v);
    logic signed [8:0] w;
    w = {v[7], v};
    return w[8] ? $unsigned(-w) : $unsigned(w);
  endfunction

  // Flip the MSB to centre the axis, then squash small deflections to zero.
  always_comb begin
    d   = raw ^ CENTRE;
    val = (mag9(d) <= 9'(DEADZONE)) ? 8'sd0 : d;
  end

endmodule

// File: rtl/psone_report.sv
// PS1 pad response decoder: collects 9-byte packets, validates them and
// presents active-high, centred reports on a valid/ready handshake.
module psone_report
  import psone_pkg::*;
#(
  parameter int          DEADZONE    = 8,
  parameter logic [23:0] TIMEOUT_CYC = 24'd12_000_000
) (
  input logic           iCLK,
  input logic           iRESET,
  psone_report_if.slave bus
);

  state_e            state_q, state_d;
  logic [8:1][7:0]   pkt_q, pkt_d;
  logic [3:0]        idx_q, idx_d;
  logic [23:0]       tmr_q, tmr_d;
  logic              timeout, pkt_abort, hdr_ok, chk_ok, chk_bad;
  logic              err_q, err_d, drop_q, drop_d, chg_q, chg_d;
  logic              out_vld_q, out_vld_d, pend_vld_q, pend_vld_d, xfer;
  logic [7:0]        errcnt_q, errcnt_d;
  report_t           out_q, out_d, pend_q, pend_d, snap_q, snap_d, new_rep;
  logic signed [7:0] ax_rx, ax_ry, ax_lx, ax_ly;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  psone_axis #(.DEADZONE(DEADZONE)) u_rx (.raw(pkt_q[5]), .val(ax_rx));
  psone_axis #(.DEADZONE(DEADZONE)) u_ry (.raw(pkt_q[6]), .val(ax_ry));
  psone_axis #(.DEADZONE(DEADZONE)) u_lx (.raw(pkt_q[7]), .val(ax_lx));
  psone_axis #(.DEADZONE(DEADZONE)) u_ly (.raw(pkt_q[8]), .val(ax_ly));

  assign timeout = (tmr_q == TIMEOUT_CYC - 24'd1) && !bus.iBYTE_VAL;
  assign xfer    = out_vld_q && bus.iRDY;

  // State and control register; every visible output clears on reset.
  always_ff @(posedge iCLK) begin
    if (!iRESET) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      tmr_q      <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
      chg_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      pend_vld_q <= 1'b0;
      errcnt_q   <= '0;
      out_q      <= '0;
      pend_q     <= '0;
      snap_q     <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      tmr_q      <= tmr_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
      chg_q      <= chg_d;
      out_vld_q  <= out_vld_d;
      pend_vld_q <= pend_vld_d;
      errcnt_q   <= errcnt_d;
      out_q      <= out_d;
      pend_q     <= pend_d;
      snap_q     <= snap_d;
    end
  end

  // Packet byte storage; stale bytes are harmless because idx restarts.
  always_ff @(posedge iCLK) begin
    pkt_q <= pkt_d;
  end

  // Next-state: a start byte may open a new packet from any state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (bus.iBYTE_VAL && bus.iPKT_ST) state_d = ST_COLLECT;
      ST_COLLECT: begin
        if (bus.iBYTE_VAL && !bus.iPKT_ST && idx_q == 4'd8) state_d = ST_CHECK;
        else if (timeout)                                    state_d = ST_IDLE;
      end
      ST_CHECK:   state_d = (bus.iBYTE_VAL && bus.iPKT_ST) ? ST_COLLECT : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Byte capture, inter-byte timer and abort detection.
  always_comb begin
    idx_d     = idx_q;
    pkt_d     = pkt_q;
    tmr_d     = tmr_q;
    pkt_abort = 1'b0;
    if (state_q == ST_COLLECT) begin
      if (bus.iBYTE_VAL) begin
        tmr_d = '0;
        if (bus.iPKT_ST) begin
          pkt_abort = 1'b1;
          idx_d     = 4'd1;
        end else begin
          for (int i = 1; i <= 8; i++)
            if (idx_q == 4'(i)) pkt_d[i] = bus.iBYTE;
          idx_d = idx_q + 4'd1;
        end
      end else if (timeout) begin
        pkt_abort = 1'b1;
      end else begin
        tmr_d = tmr_q + 24'd1;
      end
    end else if (bus.iBYTE_VAL && bus.iPKT_ST) begin
      idx_d = 4'd1;
      tmr_d = '0;
    end
  end

  // Header check and report formatting of the collected packet.
  always_comb begin
    hdr_ok  = (pkt_q[2] == MARKER) && (id_to_mode(pkt_q[1]) != MODE_NONE);
    chk_ok  = (state_q == ST_CHECK) && hdr_ok;
    chk_bad = (state_q == ST_CHECK) && !hdr_ok;
    err_d   = pkt_abort || chk_bad;
    new_rep.buttons = ~{pkt_q[4], pkt_q[3]};
    new_rep.mode    = id_to_mode(pkt_q[1]);
    if (new_rep.mode == MODE_DIG) begin
      new_rep.rx = '0;
      new_rep.ry = '0;
      new_rep.lx = '0;
      new_rep.ly = '0;
    end else begin
      new_rep.rx = ax_rx;
      new_rep.ry = ax_ry;
      new_rep.lx = ax_lx;
      new_rep.ly = ax_ly;
    end
  end

  // Output stage: output regs, one-deep pending slot, snapshot, counters.
  // On a transfer the outgoing report becomes the snapshot, so oCHANGED of
  // the next presented report compares against out_q in that cycle.
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    snap_d     = xfer ? out_q : snap_q;
    chg_d      = chg_q;
    drop_d     = 1'b0;
    errcnt_d   = err_d ? sat_inc(errcnt_q) : errcnt_q;
    if (chk_ok) begin
      if (!out_vld_q || (xfer && !pend_vld_q)) begin
        out_d     = new_rep;
        out_vld_d = 1'b1;
        chg_d     = (new_rep != (xfer ? out_q : snap_q));
      end else if (xfer) begin
        out_d  = pend_q;
        chg_d  = (pend_q != out_q);
        pend_d = new_rep;
      end else begin
        drop_d     = pend_vld_q;
        pend_d     = new_rep;
        pend_vld_d = 1'b1;
      end
    end else if (xfer) begin
      if (pend_vld_q) begin
        out_d      = pend_q;
        chg_d      = (pend_q != out_q);
        pend_vld_d = 1'b0;
      end else begin
        out_vld_d = 1'b0;
      end
    end
  end

  assign bus.oREP_VAL = out_vld_q;
  assign bus.oBUTTONS = out_q.buttons;
  assign bus.oRX      = out_q.rx;
  assign bus.oRY      = out_q.ry;
  assign bus.oLX      = out_q.lx;
  assign bus.oLY      = out_q.ly;
  assign bus.oMODE    = out_q.mode;
  assign bus.oCHANGED = chg_q;
  assign bus.oERR     = err_q;
  assign bus.oDROP    = drop_q;
  assign bus.oERR_CNT = errcnt_q;

endmodule
